// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- constants shared by the pipeline controller files.
//   FSM state encodings, NOP instruction word, zero register index, and the
//   bundle of per-stage control strobes produced every cycle.
package pipe_ctrl_pkg;

  localparam logic [1:0]  ST_RUN     = 2'd0;
  localparam logic [1:0]  ST_FLUSH   = 2'd1;
  localparam logic [1:0]  ST_MC_WAIT = 2'd2;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [4:0]  ZERO_REG   = 5'd0;

  typedef struct packed {
    logic pc_load;
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_bubble;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// ctrl_hazard_cmp -- combinational load-use hazard detector.
//   i_ex_is_load, i_ex_reg_wen, i_ex_rd_addr : instruction in ex
//   i_id_rs*_addr, i_id_rs*_used             : instruction in id
//   o_hazard : id needs a register the ex load has not produced yet
module ctrl_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       i_ex_is_load,
  input  logic       i_ex_reg_wen,
  input  logic [4:0] i_ex_rd_addr,
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  output logic       o_hazard
);

  logic w_ld_wr;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real dependency
  assign w_ld_wr   = i_ex_is_load & i_ex_reg_wen & (i_ex_rd_addr != ZERO_REG);
  assign w_rs1_hit = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
  assign o_hazard  = w_ld_wr & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencer for the 5-stage RV32I core.
//   Redirects the PC on ex jumps, squashes wrong-path instructions for
//   FLUSH_CYCLES cycles, freezes the front end while a multi-cycle ex op is
//   busy, and inserts single load-use bubbles.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   jump_en_i, jump_addr_i     : ex redirect request and target
//   mc_busy_i                  : ex multi-cycle op in progress
//   ex_*/id_* hazard inputs    : load-use detection
//   pc_load_o, pc_load_addr_o  : PC redirect
//   *_hold_o, *_flush_o, id_ex_bubble_o : stage controls (combinational)
//   err_o                      : sticky multi-cycle timeout
//   stall_cnt_o, flush_cnt_o   : perf counters, built only with
//                                PIPE_CTRL_PERF_EN defined, else tied to 0
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        mc_busy_i,
  input  logic        ex_is_load_i,
  input  logic        ex_reg_wen_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  output logic        pc_load_o,
  output logic [31:0] pc_load_addr_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_hold_o,
  output logic        id_ex_bubble_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MC_LIMIT  = 8'(MC_TIMEOUT);

  logic [1:0] r_state,  w_state_nxt;
  logic [3:0] r_fl_cnt, w_fl_cnt_nxt;
  logic [7:0] r_mc_cnt, w_mc_cnt_nxt;
  logic       r_err;
  logic       w_hazard;
  ctrl_t      w_ctrl;

  ctrl_hazard_cmp u_hazard (
    .i_ex_is_load  (ex_is_load_i),
    .i_ex_reg_wen  (ex_reg_wen_i),
    .i_ex_rd_addr  (ex_rd_addr_i),
    .i_id_rs1_addr (id_rs1_addr_i),
    .i_id_rs2_addr (id_rs2_addr_i),
    .i_id_rs1_used (id_rs1_used_i),
    .i_id_rs2_used (id_rs2_used_i),
    .o_hazard      (w_hazard)
  );

  always_comb begin
    w_ctrl       = '0;
    w_state_nxt  = r_state;
    w_fl_cnt_nxt = r_fl_cnt;
    w_mc_cnt_nxt = r_mc_cnt;
    case (r_state)
      ST_RUN: begin
        if (jump_en_i) begin
          w_ctrl.pc_load      = 1'b1;
          w_ctrl.if_id_flush  = 1'b1;
          w_ctrl.id_ex_bubble = 1'b1;
          // the jump cycle itself is the first squash cycle
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt  = ST_FLUSH;
            w_fl_cnt_nxt = FL_RELOAD;
          end
        end else if (mc_busy_i) begin
          w_ctrl.pc_hold    = 1'b1;
          w_ctrl.if_id_hold = 1'b1;
          w_ctrl.id_ex_hold = 1'b1;
          w_state_nxt       = ST_MC_WAIT;
          w_mc_cnt_nxt      = 8'd1;
        end else if (w_hazard) begin
          w_ctrl.pc_hold      = 1'b1;
          w_ctrl.if_id_hold   = 1'b1;
          w_ctrl.id_ex_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_ctrl.if_id_flush  = 1'b1;
        w_ctrl.id_ex_bubble = 1'b1;
        if (jump_en_i) begin
          w_ctrl.pc_load = 1'b1;
          w_fl_cnt_nxt   = FL_RELOAD;
        end else if (r_fl_cnt <= 4'd1) begin
          w_state_nxt  = ST_RUN;
          w_fl_cnt_nxt = 4'd0;
        end else begin
          w_fl_cnt_nxt = r_fl_cnt - 4'd1;
        end
      end
      ST_MC_WAIT: begin
        if (mc_busy_i) begin
          w_ctrl.pc_hold    = 1'b1;
          w_ctrl.if_id_hold = 1'b1;
          w_ctrl.id_ex_hold = 1'b1;
          if (r_mc_cnt != 8'hFF) w_mc_cnt_nxt = r_mc_cnt + 8'd1;
        end else begin
          w_state_nxt  = ST_RUN;
          w_mc_cnt_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_fl_cnt_nxt = 4'd0;
        w_mc_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_fl_cnt <= 4'd0;
      r_mc_cnt <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      // counter only climbs past 1 while busy, so this marks the
      // MC_TIMEOUT-th consecutive busy cycle
      if (w_mc_cnt_nxt == MC_LIMIT) r_err <= 1'b1;
    end
  end

  // rst forces every strobe low in the same cycle so an in-flight flush or
  // freeze is abandoned immediately; flush/bubble override hold per register
  assign pc_load_o      = ~rst & w_ctrl.pc_load;
  assign pc_load_addr_o = pc_load_o ? jump_addr_i : 32'd0;
  assign pc_hold_o      = ~rst & w_ctrl.pc_hold & ~w_ctrl.pc_load;
  assign if_id_flush_o  = ~rst & w_ctrl.if_id_flush;
  assign if_id_hold_o   = ~rst & w_ctrl.if_id_hold & ~w_ctrl.if_id_flush;
  assign id_ex_bubble_o = ~rst & w_ctrl.id_ex_bubble;
  assign id_ex_hold_o   = ~rst & w_ctrl.id_ex_hold & ~w_ctrl.id_ex_bubble;
  assign err_o          = ~rst & r_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (pc_hold_o)     r_stall_cnt <= r_stall_cnt + 32'd1;
      if (if_id_flush_o) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = rst ? 32'd0 : r_stall_cnt;
  assign flush_cnt_o = rst ? 32'd0 : r_flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Two instances share all inputs:
//   u_a : defaults (FLUSH_CYCLES=2, MC_TIMEOUT=64)
//   u_b : FLUSH_CYCLES=3, MC_TIMEOUT=4
// Output vector bit order: {pc_load, pc_hold, if_id_hold, if_id_flush,
//                           id_ex_hold, id_ex_bubble, err}
module tb_pipe_ctrl;

  localparam logic [6:0] Z = 7'b0000000;
  localparam logic [6:0] L = 7'b1001010;  // redirect + squash
  localparam logic [6:0] F = 7'b0001010;  // squash only
  localparam logic [6:0] H = 7'b0110100;  // multi-cycle freeze
  localparam logic [6:0] U = 7'b0110010;  // load-use bubble
  localparam logic [6:0] E = 7'b0000001;  // err bit

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        mc_busy;
  logic        ex_is_load, ex_reg_wen;
  logic [4:0]  ex_rd, rs1, rs2;
  logic        rs1_used, rs2_used;

  logic        a_pl, a_ph, a_ifh, a_iff, a_idh, a_idb, a_err;
  logic        b_pl, b_ph, b_ifh, b_iff, b_idh, b_idb, b_err;
  logic [31:0] a_addr, b_addr, a_stall, a_flush, b_stall, b_flush;
  logic [6:0]  vec_a, vec_b;

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipe_ctrl u_a (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .mc_busy_i(mc_busy), .ex_is_load_i(ex_is_load), .ex_reg_wen_i(ex_reg_wen),
    .ex_rd_addr_i(ex_rd), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .pc_load_o(a_pl), .pc_load_addr_o(a_addr), .pc_hold_o(a_ph),
    .if_id_hold_o(a_ifh), .if_id_flush_o(a_iff), .id_ex_hold_o(a_idh),
    .id_ex_bubble_o(a_idb), .err_o(a_err),
    .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .MC_TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .mc_busy_i(mc_busy), .ex_is_load_i(ex_is_load), .ex_reg_wen_i(ex_reg_wen),
    .ex_rd_addr_i(ex_rd), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .pc_load_o(b_pl), .pc_load_addr_o(b_addr), .pc_hold_o(b_ph),
    .if_id_hold_o(b_ifh), .if_id_flush_o(b_iff), .id_ex_hold_o(b_idh),
    .id_ex_bubble_o(b_idb), .err_o(b_err),
    .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
  );

  assign vec_a = {a_pl, a_ph, a_ifh, a_iff, a_idh, a_idb, a_err};
  assign vec_b = {b_pl, b_ph, b_ifh, b_iff, b_idh, b_idb, b_err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle: inputs already applied after the falling edge; sample 1 ns
  // later, then advance to the next falling edge
  task automatic cyc(input string tag, input logic [6:0] ea, input logic [6:0] eb,
                     input logic [31:0] eaddr);
    #1;
    chk({tag, ".a"},    32'(vec_a), 32'(ea));
    chk({tag, ".b"},    32'(vec_b), 32'(eb));
    chk({tag, ".addr"}, a_addr,     eaddr);
    if (ea[5]) exp_stall++;
    if (ea[3]) exp_flush++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    jump_en = 0; jump_addr = 32'h0; mc_busy = 0;
    ex_is_load = 0; ex_reg_wen = 0; ex_rd = 0;
    rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    cyc("rst0", Z, Z, 0);
    cyc("rst1", Z, Z, 0);
    rst = 0;
    cyc("idle", Z, Z, 0);

    // JAL to 0x100: A squashes 2 cycles, B 3 cycles
    jump_en = 1; jump_addr = 32'h100;
    cyc("jal0", L, L, 32'h100);
    jump_en = 0; jump_addr = 32'hDEAD_BEEF;
    cyc("jal1", F, F, 0);
    cyc("jal2", Z, F, 0);
    cyc("jal3", Z, Z, 0);

    // back-to-back: second jump while flushing restarts the squash window
    jump_en = 1; jump_addr = 32'h200;
    cyc("b2b0", L, L, 32'h200);
    jump_addr = 32'h300;
    cyc("b2b1", L, L, 32'h300);
    jump_en = 0;
    cyc("b2b2", F, F, 0);
    cyc("b2b3", Z, F, 0);
    cyc("b2b4", Z, Z, 0);

    // lw x5 in ex, add x6,x5,x7 in id
    ex_is_load = 1; ex_reg_wen = 1; ex_rd = 5;
    rs1 = 5; rs1_used = 1; rs2 = 7; rs2_used = 1;
    cyc("lu_rs1", U, U, 0);
    rs1 = 6; rs2 = 5;
    cyc("lu_rs2", U, U, 0);
    rs2_used = 0;
    cyc("lu_unused", Z, Z, 0);
    rs2_used = 1; ex_reg_wen = 0;
    cyc("lu_nowen", Z, Z, 0);
    ex_reg_wen = 1; ex_rd = 0; rs1 = 0; rs2 = 0;
    cyc("lu_x0", Z, Z, 0);
    ex_is_load = 0; ex_rd = 5; rs1 = 5;
    cyc("lu_noload", Z, Z, 0);

    // jump and load-use together: redirect wins, no pc_hold
    ex_is_load = 1; jump_en = 1; jump_addr = 32'h400;
    cyc("pri0", L, L, 32'h400);
    jump_en = 0;
    cyc("pri1", F, F, 0);
    cyc("pri2", U, F, 0);
    idle_inputs();
    cyc("pri3", Z, Z, 0);

    // 6 busy cycles; B times out after its 4th; jump ignored in MC_WAIT
    mc_busy = 1;
    for (int k = 1; k <= 6; k++) begin
      jump_en = (k == 3); jump_addr = (k == 3) ? 32'h500 : 32'h0;
      cyc($sformatf("mc6_%0d", k), H, (k >= 5) ? (H | E) : H, 0);
    end
    jump_en = 0; mc_busy = 0;
    cyc("mc6_end", Z, E, 0);

    // 33 busy cycles: A freezes exactly 33 cycles, no timeout at 64
    mc_busy = 1;
    for (int k = 1; k <= 33; k++)
      cyc($sformatf("mc33_%0d", k), H, H | E, 0);
    mc_busy = 0;
    cyc("mc33_end", Z, E, 0);

`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt", a_stall, 32'(exp_stall));
    chk("flush_cnt", a_flush, 32'(exp_flush));
`else
    chk("stall_cnt", a_stall, 32'd0);
    chk("flush_cnt", a_flush, 32'd0);
`endif

    // rst mid-flush: B (3-cycle squash) must abort, err cleared
    jump_en = 1; jump_addr = 32'h600;
    cyc("rf0", L, L | E, 32'h600);
    jump_en = 0; rst = 1;
    cyc("rf_rst", Z, Z, 0);
    rst = 0;
    cyc("rf1", Z, Z, 0);
    chk("stall_clr", b_stall, 32'd0);
    chk("flush_clr", b_flush, 32'd0);
    cyc("rf2", Z, Z, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
